// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one mux between up to `width` requesters.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous reset, active-low
//   req    - level-sensitive request per requester
//   en     - arbitration enable; gates new grants and preemption
//   grant  - registered one-hot grant, all-zero when idle
//   select - registered binary index of the granted requester, drives the mux select
//   valid  - high when grant is non-zero
//
// An owner keeps its grant while it keeps requesting. When max_hold is non-zero, an owner
// that has held for max_hold cycles is rotated out if anyone else is waiting and en=1.
// select holds its last value while idle so the mux output stays stable.
module mux_rr_arbiter #(
  parameter int unsigned width    = 16,
  parameter int unsigned channels = 4,
  parameter int unsigned max_hold = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [width-1:0]    req,
  input  logic                en,
  output logic [width-1:0]    grant,
  output logic [channels-1:0] select,
  output logic                valid
);

  localparam int unsigned HoldW = (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(max_hold);
  localparam logic [HoldW-1:0] HoldOne = HoldW'(1);
  // Pointer starts on the last requester so the first search begins at index 0.
  localparam logic [channels-1:0] LastRst = channels'(width - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q, state_d;
  logic [width-1:0]    grant_q, grant_d;
  logic [channels-1:0] select_q, select_d;
  logic [channels-1:0] last_q, last_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic                valid_q, valid_d;

  logic [width-1:0]    cand;
  logic                owner_req, others;
  logic                found, found_hi, found_lo;
  logic [channels-1:0] win, win_hi, win_lo;
  logic                take;

  // grant_q is zero in idle, so cand is plain req there; in grant it excludes the owner.
  assign cand      = req & ~grant_q;
  assign owner_req = |(req & grant_q);
  assign others    = |cand;

  // Cyclic search from last+1: prefer the lowest candidate above the pointer, otherwise
  // wrap to the lowest candidate at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned j = 0; j < width; j++) begin
      if (cand[j]) begin
        if (j > 32'(last_q)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            win_hi   = channels'(j);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = channels'(j);
        end
      end
    end
    found = found_hi | found_lo;
    win   = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    last_d   = last_q;
    hold_d   = hold_q;
    take     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en && found) take = 1'b1;
      end
      StGrant: begin
        if (!owner_req) begin
          // Release: hand over in the same edge when possible, else go idle.
          if (en && others) begin
            take = 1'b1;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if ((max_hold != 0) && (hold_q == HoldMax) && en && others) begin
          take = 1'b1;
        end else if ((max_hold != 0) && (hold_q != HoldMax)) begin
          hold_d = hold_q + HoldOne;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase

    if (take) begin
      state_d  = StGrant;
      grant_d  = width'(1) << win;
      select_d = win;
      last_d   = win;
      hold_d   = HoldOne;
    end

    valid_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      select_q <= '0;
      last_q   <= LastRst;
      hold_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios followed by random traffic, checked
// against a behavioural round-robin model through an expectation queue.
module tb_mux_rr_arbiter;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int MH = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] req;
  logic         en;
  logic [W-1:0] grant;
  logic [C-1:0] select;
  logic         valid;

  mux_rr_arbiter #(
    .width   (W),
    .channels(C),
    .max_hold(MH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (en),
    .grant (grant),
    .select(select),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] grant;
    logic [C-1:0] select;
    logic         valid;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Reference model: owner index (-1 = idle), rotation pointer, hold length, select.
  int m_owner;
  int m_last;
  int m_hold;
  int m_sel;

  function automatic int rr_pick(input logic [W-1:0] r, input int from);
    for (int k = 1; k <= W; k++) begin
      if (r[(from + k) % W]) return (from + k) % W;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r_n, input logic [W-1:0] r, input logic e);
    logic [W-1:0] rest;
    int           w;
    if (!r_n) begin
      m_owner = -1;
      m_last  = W - 1;
      m_hold  = 0;
      m_sel   = 0;
      return;
    end
    if (m_owner < 0) begin
      w = rr_pick(r, m_last);
      if (e && w >= 0) begin
        m_owner = w; m_last = w; m_hold = 1; m_sel = w;
      end
      return;
    end
    rest = r;
    rest[m_owner] = 1'b0;
    w = rr_pick(rest, m_last);
    if (!r[m_owner]) begin
      if (e && w >= 0) begin
        m_owner = w; m_last = w; m_hold = 1; m_sel = w;
      end else begin
        m_owner = -1; m_hold = 0;
      end
    end else if (MH != 0 && m_hold == MH && e && w >= 0) begin
      m_owner = w; m_last = w; m_hold = 1; m_sel = w;
    end else begin
      m_hold = (MH == 0) ? 1 : ((m_hold + 1 > MH) ? MH : m_hold + 1);
    end
  endtask

  // Apply inputs for the next edge, push the expected post-edge outputs, advance one cycle.
  task automatic drive(input logic r_n, input logic [W-1:0] r, input logic e);
    exp_t x;
    rst_n = r_n;
    req   = r;
    en    = e;
    model_step(r_n, r, e);
    cyc_no++;
    x.grant  = (m_owner < 0) ? '0 : (W'(1) << m_owner);
    x.select = C'(m_sel);
    x.valid  = (m_owner >= 0);
    x.cyc    = cyc_no;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks += 3;
      if (grant !== x.grant) begin
        errors++;
        $display("FAIL grant cycle=%0d got=%h exp=%h", x.cyc, grant, x.grant);
      end
      if (select !== x.select) begin
        errors++;
        $display("FAIL select cycle=%0d got=%0d exp=%0d", x.cyc, select, x.select);
      end
      if (valid !== x.valid) begin
        errors++;
        $display("FAIL valid cycle=%0d got=%b exp=%b", x.cyc, valid, x.valid);
      end
    end
  end

  initial begin
    logic [W-1:0] r;
    rst_n = 1'b0;
    req   = '0;
    en    = 1'b0;

    // Reset with everyone requesting, then the first grant goes to index 0.
    drive(1'b0, 16'hFFFF, 1'b1);
    drive(1'b0, 16'hFFFF, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 16'hFFFF, 1'b1);

    // Rotation 0 -> 3 -> 9 -> 0: each owner drops its request once it holds the grant.
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      r = 16'h0209;
      if (m_owner >= 0) r[m_owner] = 1'b0;
      drive(1'b1, r, 1'b1);
    end

    // Preemption between requesters 0 and 4.
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, 16'h0011, 1'b1);

    // Lone requester is never preempted.
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 16'h0100, 1'b1);

    // Enable gating: owner 2 keeps its grant past max_hold, release goes idle.
    drive(1'b0, '0, 1'b1);
    drive(1'b1, 16'h0004, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h0024, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b1, 16'h0020, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b1, 16'h0020, 1'b1);

    // Reset mid-grant restores the pointer.
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0080, 1'b1);
    drive(1'b0, 16'h0080, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0180, 1'b1);

    // Random traffic with sticky, sparse requests.
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) r = W'($urandom & $urandom);
      drive(($urandom_range(63) != 0), r, ($urandom_range(3) != 0));
    end

    // Drain: every pushed expectation must be consumed by the monitor.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
